// File: rtl/fetch_stage.sv
// Fetch stage: owns the PC, addresses instruction memory and fills the IF/ID register.
// Optional FETCH_PERF_COUNTERS_EN adds fetch/bubble event counters.
module fetch_stage #(
    parameter int unsigned PC_WIDTH                         = 32,
    parameter int unsigned INSTRUCTION_WIDTH                = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC                 = '0,
    parameter logic [PC_WIDTH-1:0] PC_STEP                  = 1,
    parameter logic [INSTRUCTION_WIDTH-1:0] NOP_INSTR       = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         stall_i,
    input  logic                         flush_i,
    input  logic                         branch_taken_i,
    input  logic [PC_WIDTH-1:0]          branch_target_i,
    output logic [PC_WIDTH-1:0]          imem_addr_o,
    input  logic [INSTRUCTION_WIDTH-1:0] imem_instr_i,
    output logic [INSTRUCTION_WIDTH-1:0] ifid_instr_o,
    output logic [PC_WIDTH-1:0]          ifid_pc_o,
    output logic [PC_WIDTH-1:0]          ifid_pc_next_o,
    output logic                         ifid_valid_o
`ifdef FETCH_PERF_COUNTERS_EN
    ,
    output logic [31:0]                  fetch_count_o,
    output logic [31:0]                  bubble_count_o
`endif
);

    logic [PC_WIDTH-1:0]          pc_q, pc_d, pc_inc;
    logic [INSTRUCTION_WIDTH-1:0] instr_q, instr_d;
    logic [PC_WIDTH-1:0]          ifid_pc_q, ifid_pc_d;
    logic [PC_WIDTH-1:0]          ifid_pc_next_q, ifid_pc_next_d;
    logic                         valid_q, valid_d;
    logic                         do_fetch, do_bubble;

    assign pc_inc      = pc_q + PC_STEP;
    assign imem_addr_o = pc_q;

    // Branch redirect beats stall and flush; a stalled flush still squashes IF/ID.
    always_comb begin
        pc_d           = pc_q;
        instr_d        = instr_q;
        ifid_pc_d      = ifid_pc_q;
        ifid_pc_next_d = ifid_pc_next_q;
        valid_d        = valid_q;
        do_fetch       = 1'b0;
        do_bubble      = 1'b0;

        if (branch_taken_i) begin
            pc_d      = branch_target_i;
            do_bubble = 1'b1;
        end else if (stall_i && flush_i) begin
            do_bubble = 1'b1;
        end else if (stall_i) begin
            do_bubble = 1'b0;
        end else if (flush_i) begin
            pc_d      = pc_inc;
            do_bubble = 1'b1;
        end else begin
            pc_d     = pc_inc;
            do_fetch = 1'b1;
        end

        if (do_bubble) begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end
        if (do_fetch) begin
            instr_d        = imem_instr_i;
            ifid_pc_d      = pc_q;
            ifid_pc_next_d = pc_inc;
            valid_d        = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q           <= RESET_PC;
            instr_q        <= NOP_INSTR;
            ifid_pc_q      <= '0;
            ifid_pc_next_q <= '0;
            valid_q        <= 1'b0;
        end else begin
            pc_q           <= pc_d;
            instr_q        <= instr_d;
            ifid_pc_q      <= ifid_pc_d;
            ifid_pc_next_q <= ifid_pc_next_d;
            valid_q        <= valid_d;
        end
    end

    assign ifid_instr_o   = instr_q;
    assign ifid_pc_o      = ifid_pc_q;
    assign ifid_pc_next_o = ifid_pc_next_q;
    assign ifid_valid_o   = valid_q;

`ifdef FETCH_PERF_COUNTERS_EN
    logic [31:0] fetch_count_q, bubble_count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_count_q  <= '0;
            bubble_count_q <= '0;
        end else begin
            if (do_fetch) begin
                fetch_count_q <= fetch_count_q + 32'd1;
            end
            if (do_bubble) begin
                bubble_count_q <= bubble_count_q + 32'd1;
            end
        end
    end

    assign fetch_count_o  = fetch_count_q;
    assign bubble_count_o = bubble_count_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized control traffic
// compared against a behavioural model of the fetch rules.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i, flush_i, branch_taken_i;
    logic [31:0] branch_target_i;
    logic [31:0] imem_addr_o, imem_instr_i;
    logic [31:0] ifid_instr_o, ifid_pc_o, ifid_pc_next_o;
    logic        ifid_valid_o;
`ifdef FETCH_PERF_COUNTERS_EN
    logic [31:0] fetch_count_o, bubble_count_o;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] m_pc, m_instr, m_pco, m_pcn, m_fc, m_bc;
    logic        m_valid;

    always #5 clk = ~clk;

    // Memory contents: word k holds k + 100.
    assign imem_instr_i = imem_addr_o + 32'd100;

    fetch_stage dut (
        .clk            (clk),
        .rst            (rst),
        .stall_i        (stall_i),
        .flush_i        (flush_i),
        .branch_taken_i (branch_taken_i),
        .branch_target_i(branch_target_i),
        .imem_addr_o    (imem_addr_o),
        .imem_instr_i   (imem_instr_i),
        .ifid_instr_o   (ifid_instr_o),
        .ifid_pc_o      (ifid_pc_o),
        .ifid_pc_next_o (ifid_pc_next_o),
        .ifid_valid_o   (ifid_valid_o)
`ifdef FETCH_PERF_COUNTERS_EN
        ,
        .fetch_count_o  (fetch_count_o),
        .bubble_count_o (bubble_count_o)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc    = 32'd0;
        m_instr = 32'd0;
        m_pco   = 32'd0;
        m_pcn   = 32'd0;
        m_valid = 1'b0;
        m_fc    = 32'd0;
        m_bc    = 32'd0;
    endtask

    task automatic check_all(input string ctx);
        chk({ctx, ":imem_addr"}, imem_addr_o, m_pc);
        chk({ctx, ":instr"}, ifid_instr_o, m_instr);
        chk({ctx, ":pc"}, ifid_pc_o, m_pco);
        chk({ctx, ":pc_next"}, ifid_pc_next_o, m_pcn);
        chk({ctx, ":valid"}, {31'd0, ifid_valid_o}, {31'd0, m_valid});
`ifdef FETCH_PERF_COUNTERS_EN
        chk({ctx, ":fetch_cnt"}, fetch_count_o, m_fc);
        chk({ctx, ":bubble_cnt"}, bubble_count_o, m_bc);
`endif
    endtask

    // Drive one cycle of control inputs, advance the model, and check after the edge.
    task automatic step(input logic s, input logic f, input logic b, input logic [31:0] t,
                        input string ctx);
        logic bub;
        stall_i         = s;
        flush_i         = f;
        branch_taken_i  = b;
        branch_target_i = t;
        bub = 1'b0;
        if (b) begin
            m_pc = t;
            bub  = 1'b1;
        end else if (s && f) begin
            bub = 1'b1;
        end else if (s) begin
            bub = 1'b0;
        end else if (f) begin
            m_pc = m_pc + 32'd1;
            bub  = 1'b1;
        end else begin
            m_instr = m_pc + 32'd100;
            m_pco   = m_pc;
            m_pcn   = m_pc + 32'd1;
            m_valid = 1'b1;
            m_pc    = m_pc + 32'd1;
            m_fc    = m_fc + 32'd1;
        end
        if (bub) begin
            m_instr = 32'd0;
            m_valid = 1'b0;
            m_bc    = m_bc + 32'd1;
        end
        @(posedge clk);
        #1;
        check_all(ctx);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst             = 1'b0;
        stall_i         = 1'b0;
        flush_i         = 1'b0;
        branch_taken_i  = 1'b0;
        branch_target_i = 32'd0;
        model_reset();
        #1;
        check_all("reset");
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Sequential fetch from RESET_PC.
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 1'b0, 1'b0, 32'd0, "seq");
            chk("seq_pc_const", ifid_pc_o, k);
            chk("seq_instr_const", ifid_instr_o, k + 100);
        end
        step(1'b0, 1'b0, 1'b0, 32'd0, "seq4");

        // Stall at pc = 5 for three cycles, then resume.
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b0, 1'b0, 32'd0, "stall");
            chk("stall_addr_const", imem_addr_o, 32'd5);
            chk("stall_pc_const", ifid_pc_o, 32'd4);
        end
        step(1'b0, 1'b0, 1'b0, 32'd0, "resume");
        chk("resume_pc_const", ifid_pc_o, 32'd5);

        // Branch overrides a concurrent stall.
        step(1'b1, 1'b0, 1'b1, 32'h40, "br_stall");
        chk("br_addr_const", imem_addr_o, 32'h40);
        chk("br_valid_const", {31'd0, ifid_valid_o}, 32'd0);
        step(1'b0, 1'b0, 1'b0, 32'd0, "after_br");
        chk("after_br_pc_const", ifid_pc_o, 32'h40);

        // Flush alone and stall+flush at pc = 8.
        step(1'b0, 1'b0, 1'b1, 32'd8, "to8");
        step(1'b0, 1'b1, 1'b0, 32'd0, "flush");
        chk("flush_addr_const", imem_addr_o, 32'd9);
        step(1'b0, 1'b0, 1'b1, 32'd8, "to8b");
        step(1'b1, 1'b1, 1'b0, 32'd0, "stall_flush");
        chk("sf_addr_const", imem_addr_o, 32'd8);

        // PC wrap at the top of the address space.
        step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, "to_max");
        step(1'b0, 1'b0, 1'b0, 32'd0, "wrap");
        chk("wrap_pcn_const", ifid_pc_next_o, 32'd0);
        chk("wrap_addr_const", imem_addr_o, 32'd0);

        // Asynchronous reset between edges.
        step(1'b0, 1'b0, 1'b0, 32'd0, "pre_rst");
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        check_all("mid_reset");
        @(posedge clk);
        #1;
        rst = 1'b1;

        // 10 fetches, 2 stalls, 1 branch.
        for (int k = 0; k < 10; k++) step(1'b0, 1'b0, 1'b0, 32'd0, "perf_f");
        for (int k = 0; k < 2; k++) step(1'b1, 1'b0, 1'b0, 32'd0, "perf_s");
        step(1'b0, 1'b0, 1'b1, 32'h100, "perf_b");
`ifdef FETCH_PERF_COUNTERS_EN
        chk("perf_fetch_const", fetch_count_o, 32'd10);
        chk("perf_bubble_const", bubble_count_o, 32'd1);
`endif

        // Randomized control traffic.
        for (int k = 0; k < 300; k++) begin
            logic s, f, b;
            logic [31:0] t;
            s = ($urandom_range(0, 3) == 0);
            f = ($urandom_range(0, 4) == 0);
            b = ($urandom_range(0, 7) == 0);
            t = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFF - $urandom_range(0, 2)) : $urandom;
            step(s, f, b, t, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
